// File: rtl/lcd_cmd_if.sv
// Command channel between the control-word source, the LCD command queue and the LCD controller.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are
// both high; valid and the payload stay stable until that edge, and ready may rise or fall freely.
interface lcd_cmd_if #(
   parameter int ADDR_W = 8,
   parameter int CTRL_W = 8,
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_addr, in_ctrl, in_data, out_ready,
      input  in_ready, out_valid, out_addr, out_ctrl, out_data
   );

   modport slave (
      input  in_valid, in_addr, in_ctrl, in_data, out_ready,
      output in_ready, out_valid, out_addr, out_ctrl, out_data
   );
endinterface

// File: rtl/lcd_cmd_queue.sv
// Ordered {addr,ctrl,data} command queue feeding the LCD controller, with a forced idle gap
// after every issued command so the panel can settle.
module lcd_cmd_queue #(
   parameter int ADDR_W  = 8,
   parameter int CTRL_W  = 8,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 8,
   parameter int MIN_GAP = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     clr_ovf,
   lcd_cmd_if.slave                 bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [1:0]               state_dbg
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CMD_W = ADDR_W + CTRL_W + DATA_W;
   localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [CMD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [GAP_W-1:0] gap_cnt;
   logic [LVL_W-1:0] level_nxt;
   logic [CMD_W-1:0] head;
   logic             push, pop, drop, show;

   // in_ready looks only at the registered level, so a full queue never takes a push
   // even when the head leaves in the same cycle.
   assign bus.in_ready = (level != LVL_W'(DEPTH));
   assign push = bus.in_valid && bus.in_ready && !flush;
   assign drop = bus.in_valid && !bus.in_ready && !flush;
   assign pop  = show && bus.out_ready && !flush;

   always_comb begin
      level_nxt = level;
      if (push && !pop)
         level_nxt = level + 1'b1;
      else if (pop && !push)
         level_nxt = level - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {bus.in_addr, bus.in_ctrl, bus.in_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         gap_cnt <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         gap_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         if (pop && (MIN_GAP > 0))
            gap_cnt <= GAP_W'(MIN_GAP - 1);
         else if ((state == GAP) && (gap_cnt != '0))
            gap_cnt <= gap_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
      else if (clr_ovf)
         overflow <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Decisions use the post-edge level so a push landing this edge is shown next cycle.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (level_nxt != '0) state_nxt = SHOW;
            SHOW: begin
               if (pop) begin
                  if (MIN_GAP > 0)
                     state_nxt = GAP;
                  else
                     state_nxt = (level_nxt != '0) ? SHOW : IDLE;
               end
            end
            GAP:  if (gap_cnt == '0) state_nxt = (level_nxt != '0) ? SHOW : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      show      = 1'b0;
      state_dbg = state;
      if (state == SHOW)
         show = 1'b1;
   end

   assign head          = mem[rd_ptr];
   assign bus.out_valid = show;
   assign bus.out_addr  = show ? head[CMD_W-1 -: ADDR_W]         : '0;
   assign bus.out_ctrl  = show ? head[DATA_W +: CTRL_W]          : '0;
   assign bus.out_data  = show ? head[DATA_W-1:0]                : '0;
endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Bench for lcd_cmd_queue: one instance with a 2-cycle settle gap, one back-to-back, both
// compared cycle by cycle against a queue-plus-cooldown reference model.
module tb_lcd_cmd_queue;
   localparam int DEPTH = 8;
   localparam int W     = 24;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       sel;
   logic       d_valid, d_ready, d_flush, d_clr;
   logic [7:0] d_addr, d_ctrl, d_data;

   logic [3:0] level_g, level_z;
   logic       ovf_g, ovf_z;
   logic [1:0] dbg_g, dbg_z;

   lcd_cmd_if #(.ADDR_W(8), .CTRL_W(8), .DATA_W(8)) bus_g ();
   lcd_cmd_if #(.ADDR_W(8), .CTRL_W(8), .DATA_W(8)) bus_z ();

   assign bus_g.in_valid  = !sel && d_valid;
   assign bus_g.in_addr   = d_addr;
   assign bus_g.in_ctrl   = d_ctrl;
   assign bus_g.in_data   = d_data;
   assign bus_g.out_ready = !sel && d_ready;
   assign bus_z.in_valid  = sel && d_valid;
   assign bus_z.in_addr   = d_addr;
   assign bus_z.in_ctrl   = d_ctrl;
   assign bus_z.in_data   = d_data;
   assign bus_z.out_ready = sel && d_ready;

   lcd_cmd_queue #(.DEPTH(DEPTH), .MIN_GAP(2)) dut_g (
      .clk(clk), .rst_n(rst_n), .flush(!sel && d_flush), .clr_ovf(!sel && d_clr),
      .bus(bus_g), .level(level_g), .overflow(ovf_g), .state_dbg(dbg_g)
   );

   lcd_cmd_queue #(.DEPTH(DEPTH), .MIN_GAP(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .flush(sel && d_flush), .clr_ovf(sel && d_clr),
      .bus(bus_z), .level(level_z), .overflow(ovf_z), .state_dbg(dbg_z)
   );

   logic       o_valid, o_in_ready, o_ovf;
   logic [7:0] o_addr, o_ctrl, o_data;
   logic [3:0] o_level;
   assign o_valid    = sel ? bus_z.out_valid : bus_g.out_valid;
   assign o_in_ready = sel ? bus_z.in_ready  : bus_g.in_ready;
   assign o_addr     = sel ? bus_z.out_addr  : bus_g.out_addr;
   assign o_ctrl     = sel ? bus_z.out_ctrl  : bus_g.out_ctrl;
   assign o_data     = sel ? bus_z.out_data  : bus_g.out_data;
   assign o_level    = sel ? level_z : level_g;
   assign o_ovf      = sel ? ovf_z : ovf_g;

   // Reference model: pending commands, cycles of forced idle left, sticky overflow.
   logic [W-1:0] exp_q[$];
   int           m_cool;
   int           m_gap;
   logic         m_ovf;

   int n_vec;
   int n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_cool = 0;
      m_ovf  = 1'b0;
   endtask

   task automatic check_model();
      logic         vis;
      logic [W-1:0] hd;
      vis = (exp_q.size() != 0) && (m_cool == 0);
      hd  = vis ? exp_q[0] : '0;
      chk("out_valid", 32'(o_valid), 32'(vis));
      chk("out_cmd", 32'({o_addr, o_ctrl, o_data}), 32'(hd));
      chk("level", 32'(o_level), exp_q.size());
      chk("in_ready", 32'(o_in_ready), 32'(exp_q.size() != DEPTH));
      chk("overflow", 32'(o_ovf), 32'(m_ovf));
   endtask

   // Check the current cycle, clock one edge, then advance the model by that edge.
   task automatic tick();
      logic vis, full, do_push, do_pop, do_drop;
      full    = (exp_q.size() == DEPTH);
      vis     = (exp_q.size() != 0) && (m_cool == 0);
      do_pop  = vis && d_ready && !d_flush;
      do_push = d_valid && !full && !d_flush;
      do_drop = d_valid && full && !d_flush;
      check_model();
      @(posedge clk);
      #1;
      if (d_flush) begin
         exp_q.delete();
         m_cool = 0;
      end else begin
         if (do_pop) begin
            void'(exp_q.pop_front());
            m_cool = m_gap;
         end else if (m_cool > 0) begin
            m_cool--;
         end
         if (do_push)
            exp_q.push_back({d_addr, d_ctrl, d_data});
      end
      if (do_drop)
         m_ovf = 1'b1;
      else if (d_clr)
         m_ovf = 1'b0;
   endtask

   task automatic drive(input logic v, input logic r, input logic [7:0] a, input logic [7:0] c,
                        input logic [7:0] dd);
      d_valid = v;
      d_ready = r;
      d_addr  = a;
      d_ctrl  = c;
      d_data  = dd;
   endtask

   task automatic idle(input int n);
      d_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic random_run(input int n);
      for (int i = 0; i < n; i++) begin
         drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         d_flush = $urandom_range(0, 99) < 3;
         d_clr   = $urandom_range(0, 99) < 5;
         tick();
      end
      d_flush = 1'b0;
      d_clr   = 1'b0;
      d_ready = 1'b1;
      idle(DEPTH * 4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      int k;
      int guard;
      logic [W-1:0] hcmd;

      n_vec = 0;
      n_err = 0;
      sel   = 1'b0;
      m_gap = 2;
      d_flush = 1'b0;
      d_clr   = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      model_reset();
      rst_n = 1'b0;
      #7;
      check_model();
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single command: shown the cycle after its push, then exactly two idle cycles.
      drive(1'b1, 1'b1, 8'h01, 8'h02, 8'h03);
      tick();
      chk("t1_valid", 32'(o_valid), 32'd1);
      chk("t1_cmd", 32'({o_addr, o_ctrl, o_data}), 32'h010203);
      drive(1'b1, 1'b1, 8'h11, 8'h12, 8'h13);
      tick();
      d_valid = 1'b0;
      lows = 0;
      while (o_valid !== 1'b1 && lows < 10) begin
         lows++;
         tick();
      end
      chk("t1_gap_len", lows, 32'd2);
      tick();
      idle(3);

      // Fill to DEPTH, drop a ninth (set beats clr_ovf), drain in order.
      d_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b0, 8'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         tick();
      end
      d_valid = 1'b0;
      chk("t2_full_level", 32'(o_level), 32'd8);
      chk("t2_full_ready", 32'(o_in_ready), 32'd0);
      drive(1'b1, 1'b0, 8'hAA, 8'hBB, 8'hCC);
      d_clr = 1'b1;
      tick();
      d_clr   = 1'b0;
      d_valid = 1'b0;
      chk("t2_ovf_set", 32'(o_ovf), 32'd1);
      chk("t2_level_kept", 32'(o_level), 32'd8);
      d_ready = 1'b1;
      k = 0;
      guard = 0;
      while (k < DEPTH && guard < 100) begin
         if (o_valid === 1'b1) begin
            chk("t2_order", 32'(o_addr), k);
            k++;
         end
         tick();
         guard++;
      end
      chk("t2_drained", k, DEPTH);
      idle(3);

      // Stalled head stays put while more commands are pushed behind it.
      d_ready = 1'b0;
      hcmd = 24'h5A_C3_7E;
      drive(1'b1, 1'b0, 8'h5A, 8'hC3, 8'h7E);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)));
         tick();
         chk("t4_hold", 32'({o_addr, o_ctrl, o_data}), 32'(hcmd));
      end
      d_valid = 1'b0;
      d_ready = 1'b1;
      tick();
      chk("t5_pre_level", 32'(o_level), 32'd5);

      // Flush beats a simultaneous push and pop; overflow survives it.
      drive(1'b1, 1'b1, 8'hEE, 8'hEE, 8'hEE);
      d_flush = 1'b1;
      tick();
      d_flush = 1'b0;
      d_valid = 1'b0;
      chk("t5_level", 32'(o_level), 32'd0);
      chk("t5_valid", 32'(o_valid), 32'd0);
      chk("t5_ovf", 32'(o_ovf), 32'd1);
      d_clr = 1'b1;
      tick();
      d_clr = 1'b0;
      chk("ovf_clr", 32'(o_ovf), 32'd0);

      // Asynchronous reset in the middle of a settle gap.
      d_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'(8'h20 + i), 8'h00, 8'(i));
         tick();
      end
      d_valid = 1'b0;
      d_ready = 1'b1;
      guard = 0;
      while (o_valid !== 1'b1 && guard < 10) begin
         tick();
         guard++;
      end
      tick();
      d_ready = 1'b0;
      chk("t6_gap_level", 32'(o_level), 32'd3);
      chk("t6_gap_valid", 32'(o_valid), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(o_valid), 32'd0);
      chk("t6_rst_level", 32'(o_level), 32'd0);
      chk("t6_rst_ready", 32'(o_in_ready), 32'd1);
      chk("t6_rst_cmd", 32'({o_addr, o_ctrl, o_data}), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      random_run(400);

      // Back-to-back instance: steady push+pop, one command per cycle.
      sel   = 1'b1;
      m_gap = 0;
      model_reset();
      @(posedge clk);
      #1;
      check_model();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 8'(8'h30 + i), 8'(i), 8'h00);
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 8'(8'h40 + i), 8'(i), 8'hFF);
         chk("t3_valid", 32'(o_valid), 32'd1);
         chk("t3_level", 32'(o_level), 32'd2);
         tick();
      end
      d_valid = 1'b0;
      idle(4);

      random_run(400);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
